// File: rtl/pal_composite_pkg.sv
// Shared constants and the quarter-wave sine table for the PAL composite encoder.
// Pipeline depth depends on PAL_COMPOSITE_ENCODER_CHROMA_FILTER_EN.
package pal_composite_pkg;

   localparam logic [9:0] SYNC_LEVEL_DEF  = 10'd0;
   localparam logic [9:0] BLANK_LEVEL_DEF = 10'd288;

   localparam int LUT_DEPTH = 256;
   localparam int LUT_AMP   = 127;

`ifdef PAL_COMPOSITE_ENCODER_CHROMA_FILTER_EN
   localparam int PIPE_LATENCY = 4;
`else
   localparam int PIPE_LATENCY = 3;
`endif

   // round(127*sin(2*pi*k/256)) for k = 0..63; k = 64 is the peak.
   localparam logic [6:0] Q_TBL [0:63] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
   };

   function automatic logic signed [8:0] quarter_sine(input logic [6:0] m);
      if (m >= 7'd64) return 9'(LUT_AMP);
      return {2'b00, Q_TBL[m[5:0]]};
   endfunction

endpackage

// File: rtl/pal_sine_lut.sv
// Registered sin/cos lookup for an 8-bit phase, built from the quarter-wave table.
// One cycle from i_phase to o_sin/o_cos.
module pal_sine_lut
   import pal_composite_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_phase,
   output logic signed [8:0] o_sin,
   output logic signed [8:0] o_cos
);

   localparam int QTR = LUT_DEPTH / 4;

   // Mirror within the half-wave on bit 6, negate the second half-wave on bit 7.
   function automatic logic signed [8:0] sine_at(input logic [7:0] k);
      logic [6:0]        m;
      logic signed [8:0] s;
      m = {1'b0, k[5:0]};
      if (k[6]) m = 7'(QTR) - m;
      s = quarter_sine(m);
      return k[7] ? -s : s;
   endfunction

   logic [7:0]        w_cos_idx;
   logic signed [8:0] r_sin;
   logic signed [8:0] r_cos;

   assign w_cos_idx = i_phase + 8'(QTR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sin <= '0;
         r_cos <= '0;
      end else begin
         r_sin <= sine_at(i_phase);
         r_cos <= sine_at(w_cos_idx);
      end
   end

   assign o_sin = r_sin;
   assign o_cos = r_cos;

endmodule

// File: rtl/pal_composite_encoder.sv
// YUV + timing to 10-bit PAL composite: DDS subcarrier, V-switch, burst, sync tip, clamp.
// PAL_COMPOSITE_ENCODER_CHROMA_FILTER_EN adds a [1 2 1]/4 chroma FIR stage.
module pal_composite_encoder
   import pal_composite_pkg::*;
#(
   parameter logic [31:0]       PHASE_INC   = 32'd1290999816,
   parameter logic [9:0]        SYNC_LEVEL  = SYNC_LEVEL_DEF,
   parameter logic [9:0]        BLANK_LEVEL = BLANK_LEVEL_DEF,
   parameter logic signed [8:0] BURST_UV    = 9'sd45
)(
   input  logic              palClock,
   input  logic              nReset,
   input  logic signed [8:0] y,
   input  logic signed [8:0] u,
   input  logic signed [8:0] v,
   input  logic              blank,
   input  logic              sync,
   input  logic              burst,
   input  logic              burstPhase,
   output logic [9:0]        composite,
   output logic              syncOut
);

   localparam int LAT = PIPE_LATENCY;

   logic [31:0] r_phase;

   always_ff @(posedge palClock or negedge nReset) begin
      if (!nReset) r_phase <= '0;
      else         r_phase <= r_phase + PHASE_INC;
   end

   // Burst replaces U/V only in the blanked, non-sync part of the line.
   logic              w_burst_gate;
   logic signed [9:0] w_burst_uv;
   logic signed [9:0] w_u_sel;
   logic signed [9:0] w_v_src;
   logic signed [9:0] w_v_sel;

   assign w_burst_gate = burst & blank & ~sync;
   assign w_burst_uv   = {BURST_UV[8], BURST_UV};
   assign w_u_sel      = w_burst_gate ? -w_burst_uv : {u[8], u};
   assign w_v_src      = w_burst_gate ?  w_burst_uv : {v[8], v};
   assign w_v_sel      = burstPhase ? -w_v_src : w_v_src;

   logic signed [8:0] w_sin;
   logic signed [8:0] w_cos;

   pal_sine_lut u_lut (
      .i_clk   (palClock),
      .i_rst_n (nReset),
      .i_phase (r_phase[31:24]),
      .o_sin   (w_sin),
      .o_cos   (w_cos)
   );

   logic signed [8:0] r1_y;
   logic signed [9:0] r1_u;
   logic signed [9:0] r1_v;
   logic [LAT-1:0]    r_sync_d;
   logic [LAT-1:0]    r_blank_d;
   logic [LAT-1:0]    r_burst_d;

   always_ff @(posedge palClock or negedge nReset) begin
      if (!nReset) begin
         r1_y      <= '0;
         r1_u      <= '0;
         r1_v      <= '0;
         r_sync_d  <= '0;
         r_blank_d <= '1;
         r_burst_d <= '0;
      end else begin
         r1_y      <= y;
         r1_u      <= w_u_sel;
         r1_v      <= w_v_sel;
         r_sync_d  <= {r_sync_d[LAT-2:0], sync};
         r_blank_d <= {r_blank_d[LAT-2:0], blank};
         r_burst_d <= {r_burst_d[LAT-2:0], burst};
      end
   end

   logic signed [9:0] w_mul_u;
   logic signed [9:0] w_mul_v;
   logic signed [8:0] w_mul_sin;
   logic signed [8:0] w_mul_cos;
   logic signed [8:0] w_mul_y;

`ifdef PAL_COMPOSITE_ENCODER_CHROMA_FILTER_EN
   logic signed [9:0]  r_u1, r_u2, r_v1, r_v2, r2_u, r2_v;
   logic signed [8:0]  r2_y, r2_sin, r2_cos;
   logic signed [11:0] w_u_fir;
   logic signed [11:0] w_v_fir;

   assign w_u_fir = {{2{r1_u[9]}}, r1_u} + {r_u1[9], r_u1, 1'b0} + {{2{r_u2[9]}}, r_u2};
   assign w_v_fir = {{2{r1_v[9]}}, r1_v} + {r_v1[9], r_v1, 1'b0} + {{2{r_v2[9]}}, r_v2};

   always_ff @(posedge palClock or negedge nReset) begin
      if (!nReset) begin
         r_u1   <= '0;
         r_u2   <= '0;
         r_v1   <= '0;
         r_v2   <= '0;
         r2_u   <= '0;
         r2_v   <= '0;
         r2_y   <= '0;
         r2_sin <= '0;
         r2_cos <= '0;
      end else begin
         r_u1   <= r1_u;
         r_u2   <= r_u1;
         r_v1   <= r1_v;
         r_v2   <= r_v1;
         r2_u   <= 10'(w_u_fir >>> 2);
         r2_v   <= 10'(w_v_fir >>> 2);
         r2_y   <= r1_y;
         r2_sin <= w_sin;
         r2_cos <= w_cos;
      end
   end

   assign w_mul_u   = r2_u;
   assign w_mul_v   = r2_v;
   assign w_mul_sin = r2_sin;
   assign w_mul_cos = r2_cos;
   assign w_mul_y   = r2_y;
`else
   assign w_mul_u   = r1_u;
   assign w_mul_v   = r1_v;
   assign w_mul_sin = w_sin;
   assign w_mul_cos = w_cos;
   assign w_mul_y   = r1_y;
`endif

   logic signed [18:0] w_prod;
   logic signed [11:0] w_y12;
   logic signed [11:0] w_y5;
   logic signed [18:0] r_prod;
   logic signed [10:0] r_luma;

   assign w_prod = ({{9{w_mul_u[9]}}, w_mul_u} * {{10{w_mul_sin[8]}}, w_mul_sin})
                 + ({{9{w_mul_v[9]}}, w_mul_v} * {{10{w_mul_cos[8]}}, w_mul_cos});
   assign w_y12  = {{3{w_mul_y[8]}}, w_mul_y};
   assign w_y5   = w_y12 + (w_y12 <<< 2);

   always_ff @(posedge palClock or negedge nReset) begin
      if (!nReset) begin
         r_prod <= '0;
         r_luma <= '0;
      end else begin
         r_prod <= w_prod;
         r_luma <= 11'(w_y5 >>> 1);
      end
   end

   logic signed [21:0] w_p22;
   logic signed [21:0] w_p5;
   logic signed [12:0] w_chroma;
   logic signed [12:0] w_base;
   logic signed [12:0] w_sum_blank;
   logic signed [12:0] w_sum_active;

   assign w_p22        = {{3{r_prod[18]}}, r_prod};
   assign w_p5         = w_p22 + (w_p22 <<< 2);
   assign w_chroma     = 13'(w_p5 >>> 8);
   assign w_base       = {3'b000, BLANK_LEVEL};
   assign w_sum_blank  = w_base + (r_burst_d[LAT-2] ? w_chroma : 13'sd0);
   assign w_sum_active = w_base + {{2{r_luma[10]}}, r_luma} + w_chroma;

   function automatic logic [9:0] clamp10(input logic signed [12:0] s);
      if (s < 13'sd0)    return 10'd0;
      if (s > 13'sd1023) return 10'd1023;
      return s[9:0];
   endfunction

   always_ff @(posedge palClock or negedge nReset) begin
      if (!nReset)                composite <= BLANK_LEVEL;
      else if (r_sync_d[LAT-2])   composite <= SYNC_LEVEL;
      else if (r_blank_d[LAT-2])  composite <= clamp10(w_sum_blank);
      else                        composite <= clamp10(w_sum_active);
   end

   assign syncOut = r_sync_d[LAT-1];

endmodule

// File: tb/tb_pal_composite_encoder.sv
// Self-checking bench for pal_composite_encoder: default-rate DUT plus a quarter-rate
// (PHASE_INC = 2^30) DUT, both checked every cycle against a behavioural model.
module tb_pal_composite_encoder;

`ifdef PAL_COMPOSITE_ENCODER_CHROMA_FILTER_EN
   localparam int LAT  = 4;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 3;
   localparam bit FILT = 1'b0;
`endif
   localparam logic [31:0] INC_D = 32'd1290999816;
   localparam logic [31:0] INC_Q = 32'h4000_0000;
   localparam int W = 21;

   logic              palClock;
   logic              nReset;
   logic signed [8:0] y, u, v;
   logic              blank, sync, burst, burstPhase;
   logic [9:0]        comp_d, comp_q;
   logic              sync_d, sync_q;

   pal_composite_encoder dut (
      .palClock   (palClock),
      .nReset     (nReset),
      .y          (y),
      .u          (u),
      .v          (v),
      .blank      (blank),
      .sync       (sync),
      .burst      (burst),
      .burstPhase (burstPhase),
      .composite  (comp_d),
      .syncOut    (sync_d)
   );

   pal_composite_encoder #(.PHASE_INC(INC_Q)) dut_q (
      .palClock   (palClock),
      .nReset     (nReset),
      .y          (y),
      .u          (u),
      .v          (v),
      .blank      (blank),
      .sync       (sync),
      .burst      (burst),
      .burstPhase (burstPhase),
      .composite  (comp_q),
      .syncOut    (sync_q)
   );

   // ---------------- clock ----------------
   initial begin
      palClock = 1'b0;
      forever #5 palClock = ~palClock;
   end

   // ---------------- model state ----------------
   typedef struct {
      int y, u, v;
      bit blank, sync, burst, bp;
   } rec_t;

   rec_t         hist[$];
   rec_t         rec;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_e;
   int           sin_tbl[256];
   int           edge_k = 0;
   int           n_tests = 0;
   int           n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int u_src(input int i);
      if (i < 0) return 0;
      if (hist[i].burst && hist[i].blank && !hist[i].sync) return -45;
      return hist[i].u;
   endfunction

   function automatic int v_src(input int i);
      int r;
      if (i < 0) return 0;
      r = (hist[i].burst && hist[i].blank && !hist[i].sync) ? 45 : hist[i].v;
      return hist[i].bp ? -r : r;
   endfunction

   // Expected composite for the sample captured on edge i+1 after reset.
   function automatic int model_comp(input int i, input logic [31:0] inc);
      int          us, vs, idx, pr, lu, ch, s;
      logic [31:0] ph;
      if (FILT) begin
         us = (u_src(i) + 2 * u_src(i - 1) + u_src(i - 2)) >>> 2;
         vs = (v_src(i) + 2 * v_src(i - 1) + v_src(i - 2)) >>> 2;
      end else begin
         us = u_src(i);
         vs = v_src(i);
      end
      ph  = inc * 32'(i);
      idx = int'(ph[31:24]);
      pr  = us * sin_tbl[idx] + vs * sin_tbl[(idx + 64) % 256];
      lu  = (hist[i].y * 5) >>> 1;
      ch  = (pr * 5) >>> 8;
      if (hist[i].sync) return 0;
      if (hist[i].blank) s = 288 + (hist[i].burst ? ch : 0);
      else               s = 288 + lu + ch;
      if (s < 0)    s = 0;
      if (s > 1023) s = 1023;
      return s;
   endfunction

   // Recorder: one expected entry per active edge.
   always @(posedge palClock or negedge nReset) begin
      if (!nReset) begin
         edge_k = 0;
         hist.delete();
         exp_q.delete();
      end else begin
         rec.y = int'(y);  rec.u = int'(u);  rec.v = int'(v);
         rec.blank = blank; rec.sync = sync; rec.burst = burst; rec.bp = burstPhase;
         hist.push_back(rec);
         edge_k++;
         if (edge_k < LAT)
            exp_q.push_back({1'b0, 10'd288, 10'd288});
         else
            exp_q.push_back({hist[edge_k - LAT].sync,
                             10'(model_comp(edge_k - LAT, INC_D)),
                             10'(model_comp(edge_k - LAT, INC_Q))});
      end
   end

   // Compare process, away from the active edge.
   always @(negedge palClock) begin
      if (!nReset) begin
         check("reset_comp",   int'(comp_d), 288);
         check("reset_comp_q", int'(comp_q), 288);
         check("reset_sync",   int'(sync_d), 0);
      end else if (exp_q.size() > 0) begin
         exp_e = exp_q.pop_front();
         check("comp",   int'(comp_d), int'(exp_e[19:10]));
         check("comp_q", int'(comp_q), int'(exp_e[9:0]));
         check("sync",   int'(sync_d), int'(exp_e[20]));
         check("sync_q", int'(sync_q), int'(exp_e[20]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input int yy, input int uu, input int vv,
                         input bit bl, input bit sy, input bit bu, input bit bp);
      y = 9'(yy); u = 9'(uu); v = 9'(vv);
      blank = bl; sync = sy; burst = bu; burstPhase = bp;
   endtask

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge palClock);
         #2;
      end
   endtask

   function automatic int rnd9();
      return int'($urandom_range(0, 511)) - 256;
   endfunction

   int luma_y[4]   = '{0, 255, -10, -256};
   int luma_exp[4] = '{288, 925, 263, 0};
   int burst0[4]   = '{399, 176, 176, 399};
   int burst1[4]   = '{176, 176, 399, 399};
   int clamp_x[4]  = '{972, 719, 877, 1023};
   int filt25[4]   = '{288, 350, 288, 225};
   int filt75[4]   = '{288, 474, 288, 101};
   int filt100[4]  = '{288, 536, 288, 39};

   initial begin
      real r;
      for (int k = 0; k < 256; k++) begin
         r = 127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
         sin_tbl[k] = $rtoi($floor(r + 0.5));
      end

      set_in(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      nReset = 1'b1;
      #1 nReset = 1'b0;
      repeat (4) @(posedge palClock);
      #2;
      check("reset_hold_comp", int'(comp_d), 288);
      check("reset_hold_sync", int'(sync_d), 0);
      nReset = 1'b1;
      hold(LAT + 2);

      for (int i = 0; i < 4; i++) begin
         set_in(luma_y[i], 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
         hold(LAT);
         check("luma", int'(comp_d), luma_exp[i]);
         check("luma_q", int'(comp_q), luma_exp[i]);
      end

      // Sync appears exactly LAT cycles after it is presented.
      set_in(255, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(LAT);
      set_in(255, rnd9(), rnd9(), 1'b1, 1'b1, 1'b0, 1'b0);
      hold(LAT - 1);
      check("sync_early_comp", int'(comp_d), 925);
      check("sync_early_out",  int'(sync_d), 0);
      hold(1);
      check("sync_comp", int'(comp_d), 0);
      check("sync_out",  int'(sync_d), 1);

      set_in(255, rnd9(), rnd9(), 1'b1, 1'b1, 1'b1, 1'b0);
      hold(LAT);
      check("sync_over_burst", int'(comp_q), 0);

      set_in(200, rnd9(), rnd9(), 1'b1, 1'b0, 1'b0, 1'b1);
      hold(LAT);
      check("blank_no_burst", int'(comp_d), 288);

      set_in(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(LAT);
      check("burst_outside_blank", int'(comp_q), 288);

      set_in(0, rnd9(), rnd9(), 1'b1, 1'b0, 1'b1, 1'b0);
      hold(LAT);
      for (int j = 0; j < 4; j++) begin
         check("burst_bp0", int'(comp_q), burst0[(edge_k - LAT) % 4]);
         hold(1);
      end
      set_in(0, rnd9(), rnd9(), 1'b1, 1'b0, 1'b1, 1'b1);
      hold(LAT);
      for (int j = 0; j < 4; j++) begin
         check("burst_bp1", int'(comp_q), burst1[(edge_k - LAT) % 4]);
         hold(1);
      end

      set_in(255, -83, 19, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(LAT);
      for (int j = 0; j < 4; j++) begin
         check("clamp", int'(comp_q), clamp_x[(edge_k - LAT) % 4]);
         hold(1);
      end

      if (FILT) begin
         set_in(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
         hold(LAT + 3);
         set_in(0, 100, 0, 1'b0, 1'b0, 1'b0, 1'b0);
         hold(LAT);
         check("filt_25", int'(comp_q), filt25[(edge_k - LAT) % 4]);
         hold(1);
         check("filt_75", int'(comp_q), filt75[(edge_k - LAT) % 4]);
         hold(1);
         check("filt_100", int'(comp_q), filt100[(edge_k - LAT) % 4]);
      end

      // Mid-line reset takes effect before the next edge; refill takes LAT edges.
      set_in(255, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(LAT);
      check("pre_reset", int'(comp_d), 925);
      nReset = 1'b0;
      #1;
      check("midreset_comp", int'(comp_d), 288);
      check("midreset_sync", int'(sync_d), 0);
      hold(2);
      nReset = 1'b1;
      hold(LAT - 1);
      check("refill_early", int'(comp_d), 288);
      hold(1);
      check("refill", int'(comp_d), 925);

      for (int n = 0; n < 3000; n++) begin
         bit bl, sy;
         bl = ($urandom_range(0, 3) == 0);
         sy = bl && ($urandom_range(0, 2) == 0);
         set_in(rnd9(), rnd9(), rnd9(), bl, sy,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 999) == 0) begin
            nReset = 1'b0;
            hold(2);
            nReset = 1'b1;
         end
         hold(1);
      end

      hold(LAT + 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
